// File: rtl/lock_pkg.sv
// Shared types and default constants for the lock supervisor.
//   state_e       : supervisor FSM state encoding (2-bit)
//   DEF_*         : default parameter values used by the top module
//   FAIL_W        : width of the consecutive-failure counter
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } state_e;

    localparam int unsigned DEF_UNLOCK_CYCLES  = 8;
    localparam int unsigned DEF_MAX_FAIL       = 3;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 16;
    localparam int unsigned DEF_TW             = 8;
    localparam int unsigned FAIL_W             = 4;

endpackage

// File: rtl/lock_supervisor_if.sv
// Signal bundle between the serial-code lock and its supervisor.
//   openlock, alarm : status levels driven by the lock
//   door_unlock     : door actuator enable
//   siren, lockout  : lockout indicators; lockout gates the lock's serial input
//   fail_count      : consecutive wrong-code count
// master : lock side (drives status, observes supervisor outputs)
// slave  : supervisor side
interface lock_supervisor_if;
    import lock_pkg::*;

    logic              openlock;
    logic              alarm;
    logic              door_unlock;
    logic              siren;
    logic              lockout;
    logic [FAIL_W-1:0] fail_count;

    modport master (
        output openlock,
        output alarm,
        input  door_unlock,
        input  siren,
        input  lockout,
        input  fail_count
    );

    modport slave (
        input  openlock,
        input  alarm,
        output door_unlock,
        output siren,
        output lockout,
        output fail_count
    );

endinterface

// File: rtl/lock_edge_det.sv
// Rising-edge detector with a history register that resets to 1, so a level
// already high when reset is released does not count as an edge.
//   clk     : system clock
//   rst     : synchronous active-low reset
//   i_level : level input, sampled at posedge
//   o_rise  : high while i_level is 1 and was 0 at the previous edge
module lock_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/lock_supervisor.sv
// Supervisor for the serial-code lock: turns an openlock event into a timed
// door-unlock strobe and escalates MAX_FAIL consecutive alarm events into a
// timed lockout with siren. All outputs are registered (Moore).
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : lock_supervisor_if.slave (openlock/alarm in; door_unlock, siren,
//          lockout, fail_count out)
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int unsigned UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int unsigned MAX_FAIL       = DEF_MAX_FAIL,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned TW             = DEF_TW
) (
    input logic              clk,
    input logic              rst,
    lock_supervisor_if.slave bus
);

    localparam logic [TW-1:0]     UNLOCK_INIT  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]     LOCKOUT_INIT = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX     = FAIL_W'(MAX_FAIL);

    state_e            r_state;
    logic [TW-1:0]     r_timer;
    logic [FAIL_W-1:0] r_fail;
    logic              r_door;
    logic              r_siren;
    logic              r_lockout;

    logic              w_open_ev;
    logic              w_alarm_ev;
    logic [FAIL_W-1:0] w_fail_inc;
    logic              w_alarm_locks;

    lock_edge_det u_open_det (
        .clk     (clk),
        .rst     (rst),
        .i_level (bus.openlock),
        .o_rise  (w_open_ev)
    );

    lock_edge_det u_alarm_det (
        .clk     (clk),
        .rst     (rst),
        .i_level (bus.alarm),
        .o_rise  (w_alarm_ev)
    );

    // Outside LOCKOUT r_fail < MAX_FAIL <= 15, so the increment cannot wrap.
    assign w_fail_inc    = r_fail + FAIL_W'(1);
    assign w_alarm_locks = (w_fail_inc >= FAIL_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_fail    <= '0;
            r_door    <= 1'b0;
            r_siren   <= 1'b0;
            r_lockout <= 1'b0;
        end else begin
            case (r_state)
                IDLE, UNLOCKED: begin
                    if (w_alarm_ev) begin
                        // Alarm wins over a same-cycle open and aborts an unlock.
                        r_door <= 1'b0;
                        if (w_alarm_locks) begin
                            r_state   <= LOCKOUT;
                            r_timer   <= LOCKOUT_INIT;
                            r_fail    <= FAIL_MAX;
                            r_siren   <= 1'b1;
                            r_lockout <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_fail  <= w_fail_inc;
                        end
                    end else if (r_state == IDLE) begin
                        if (w_open_ev) begin
                            r_state <= UNLOCKED;
                            r_timer <= UNLOCK_INIT;
                            r_fail  <= '0;
                            r_door  <= 1'b1;
                        end
                    end else if (r_timer == '0) begin
                        r_state <= IDLE;
                        r_door  <= 1'b0;
                    end else begin
                        // Re-opening while unlocked does not restart the timer.
                        r_timer <= r_timer - TW'(1);
                    end
                end
                LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state   <= IDLE;
                        r_fail    <= '0;
                        r_siren   <= 1'b0;
                        r_lockout <= 1'b0;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_timer   <= '0;
                    r_fail    <= '0;
                    r_door    <= 1'b0;
                    r_siren   <= 1'b0;
                    r_lockout <= 1'b0;
                end
            endcase
        end
    end

    assign bus.door_unlock = r_door;
    assign bus.siren       = r_siren;
    assign bus.lockout     = r_lockout;
    assign bus.fail_count  = r_fail;

endmodule

// File: doc/lock_supervisor.md
Name: lock_supervisor

Overview:
- Downstream consumer of the serial-code Moore lock; samples its openlock and alarm outputs.
- Turns an openlock event into a timed door-unlock strobe.
- Counts alarm events (wrong codes); after MAX_FAIL consecutive failures it enters a timed lockout with siren.
- Its lockout output gates the lock's serial input upstream.

Parameters:
- UNLOCK_CYCLES, 8, door_unlock high time in clk cycles (>=1)
- MAX_FAIL, 3, consecutive alarm events that trigger lockout (1..15)
- LOCKOUT_CYCLES, 16, lockout/siren duration in clk cycles (>=1)
- TW, 8, timer width; must hold max(UNLOCK_CYCLES, LOCKOUT_CYCLES)-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low (rst=0 at a rising clk edge resets)
- openlock  in  1  level from lock; correct code accepted
- alarm  in  1  level from lock; wrong code detected
- door_unlock  out  1  door actuator enable
- siren  out  1  audible alarm, high during lockout
- lockout  out  1  high during lockout; upstream holds the lock's serial input idle
- fail_count  out  4  consecutive failures so far

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, timer=0, fail_count=0, door_unlock=0, siren=0, lockout=0.
- Edge-detect previous-value registers reset to 1, so a level already high at reset release is not an event.
- Event definitions, from inputs sampled at posedge:
  - open_ev = openlock & ~openlock_q
  - alarm_ev = alarm & ~alarm_q
- All outputs are registered and are functions of state only (Moore). An event sampled at edge k changes outputs after edge k.
- IDLE:
  - alarm_ev and fail_count+1 < MAX_FAIL -> fail_count++, stay IDLE.
  - alarm_ev and fail_count+1 == MAX_FAIL -> LOCKOUT, timer=LOCKOUT_CYCLES-1, fail_count=MAX_FAIL.
  - open_ev with no alarm_ev -> UNLOCKED, timer=UNLOCK_CYCLES-1, fail_count=0.
  - open_ev and alarm_ev in the same cycle -> alarm takes priority and is treated as alarm_ev only.
- UNLOCKED:
  - door_unlock=1 for exactly UNLOCK_CYCLES cycles.
  - Each cycle: timer==0 -> IDLE; else timer--.
  - open_ev ignored; the timer does not restart.
  - alarm_ev aborts: door_unlock drops next cycle and the FSM applies the IDLE alarm rule (count or lockout).
- LOCKOUT:
  - siren=1 and lockout=1 for exactly LOCKOUT_CYCLES cycles.
  - open_ev and alarm_ev ignored (not counted).
  - timer==0 -> IDLE, fail_count=0.
- fail_count saturates at MAX_FAIL and never wraps.
- Edge registers update every cycle in all states, so a level held across a state exit is not re-detected.
- Reset mid-UNLOCKED or mid-LOCKOUT: immediate return to reset values at that edge.
- Illegal state encoding -> IDLE with reset values.

Decomposition:
- Package lock_pkg holds:
  - state enum {IDLE, UNLOCKED, LOCKOUT} (2-bit)
  - default parameter constants
- One natural sub-module: lock_edge_det, a rising-edge detector with reset-to-1 history. Instantiated twice (openlock, alarm).
- Timer and FSM stay in the top module.

Test Plan:
1. rst=0 for 2 cycles with openlock=1 held, then release -> no door_unlock; all outputs 0 and fail_count=0.
2. openlock pulses high for 1 cycle in IDLE -> door_unlock=1 for exactly 8 cycles starting the cycle after the sampling edge, then 0; fail_count=0.
3. Three alarm pulses separated by 4 cycles -> fail_count goes 1, 2; on the 3rd pulse lockout=siren=1 for exactly 16 cycles, then both 0 and fail_count=0.
4. During lockout, pulse openlock and alarm -> no effect; lockout length still 16 cycles and fail_count stays 3.
5. Two alarms, then an openlock pulse -> fail_count clears to 0 and door_unlock runs 8 cycles. A later alarm reaches fail_count=1, not lockout. Separately, openlock and alarm rising in the same cycle -> counted as alarm, no unlock.
6. rst=0 on the 4th cycle of UNLOCKED -> door_unlock=0 after that edge, state IDLE. An alarm held high through reset is not counted.
